// File: rtl/fifo_wr_serializer.sv
// fifo_wr_serializer
// Splits each accepted 16-bit word into two byte writes on the write side of a
// CDC FIFO, honouring the FIFO full flag as backpressure.
// Byte order is chosen by the macro WR_SER_MSB_FIRST_EN:
//   defined   -> high byte first, then low byte
//   undefined -> low byte first, then high byte (default build)
// All logic runs on the rising edge of clk_write; rst is asynchronous, active-high.

`timescale 1ns/1ps

module fifo_wr_serializer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_write,
  input  logic             rst,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             fifo_full,
  output logic             wr_en,
  output logic [7:0]       wr_data,
  output logic             busy,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_nextState;
  logic [15:0]      r_heldWord;
  logic [CNT_W-1:0] r_wordCount;
  logic [CNT_W-1:0] r_stallCount;

  logic             w_ready;
  logic             w_accept;
  logic             w_stall;
  logic             w_wrEn;
  logic [7:0]       w_wrData;
  logic [7:0]       w_firstByte;
  logic [7:0]       w_secondByte;

`ifdef WR_SER_MSB_FIRST_EN
  assign w_firstByte  = r_heldWord[15:8];
  assign w_secondByte = r_heldWord[7:0];
`else
  assign w_firstByte  = r_heldWord[7:0];
  assign w_secondByte = r_heldWord[15:8];
`endif

  // A word transfers whenever the source offers and we are ready; a stall is
  // any cycle where we hold a byte but the FIFO refuses it.
  assign w_accept = in_valid && w_ready;
  assign w_stall  = (r_state != IDLE) && fifo_full;

  // State register; reset drops any partially written word immediately.
  always_ff @(posedge clk_write or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and output decode. The second byte's cycle doubles as the
  // acceptance slot for the next word so back-to-back words leave no bubble.
  always_comb begin
    w_nextState = r_state;
    w_ready     = 1'b0;
    w_wrEn      = 1'b0;
    w_wrData    = 8'h00;
    unique case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (w_accept) begin
          w_nextState = BYTE0;
        end
      end
      BYTE0: begin
        w_wrEn   = !fifo_full;
        w_wrData = w_firstByte;
        if (!fifo_full) begin
          w_nextState = BYTE1;
        end
      end
      BYTE1: begin
        w_ready  = !fifo_full;
        w_wrEn   = !fifo_full;
        w_wrData = w_secondByte;
        if (!fifo_full) begin
          w_nextState = w_accept ? BYTE0 : IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Captures the word at acceptance so the source is free to move on.
  always_ff @(posedge clk_write or posedge rst) begin
    if (rst) begin
      r_heldWord <= 16'h0000;
    end else if (w_accept) begin
      r_heldWord <= in_data;
    end
  end

  // Accepted-word counter; wraps naturally at its width.
  always_ff @(posedge clk_write or posedge rst) begin
    if (rst) begin
      r_wordCount <= '0;
    end else if (w_accept) begin
      r_wordCount <= r_wordCount + CNT_ONE;
    end
  end

  // Backpressure counter; sticks at all-ones so a long stall never looks short.
  always_ff @(posedge clk_write or posedge rst) begin
    if (rst) begin
      r_stallCount <= '0;
    end else if (w_stall && (r_stallCount != '1)) begin
      r_stallCount <= r_stallCount + CNT_ONE;
    end
  end

  assign in_ready    = w_ready;
  assign wr_en       = w_wrEn;
  assign wr_data     = w_wrData;
  assign busy        = (r_state != IDLE);
  assign word_count  = r_wordCount;
  assign stall_count = r_stallCount;

endmodule
